le_read_addr_gen: RTL and testbench

//  Read-side counterpart of the Le write-address init store. Per window it takes the

---
 rtl/le_read_addr_gen.sv | 110 +++++++++++
 tb/tb_le_read_addr_gen.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/le_read_addr_gen.sv
// Le-memory read address generator: replays a QPP window from its stored initial
// state (A, G), emitting one address per accepted beat, forward or backward.
module le_read_addr_gen #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned WIN_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] blockSize,
    input  logic [ADDR_W-1:0] f2x2,
    input  logic              load,
    output logic              load_ready,
    input  logic              load_dir,
    input  logic [WIN_W:0]    load_len,
    input  logic [ADDR_W-1:0] load_A,
    input  logic [ADDR_W-1:0] load_G,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_last,
    output logic              win_done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] a_q, g_q, a_d, g_d;
    logic              dir_q;
    logic [WIN_W:0]    rem_q;
    logic              rd_valid_q;
    logic              win_done_q;

    logic              handshake;
    logic              final_hs;
    logic              accept;

    // Operands are already < k, so one conditional correction keeps the result < k.
    function automatic logic [ADDR_W-1:0] mod_add(input logic [ADDR_W-1:0] x,
                                                  input logic [ADDR_W-1:0] y,
                                                  input logic [ADDR_W-1:0] k);
        logic [ADDR_W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, k}) s = s - {1'b0, k};
        return s[ADDR_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] mod_sub(input logic [ADDR_W-1:0] x,
                                                  input logic [ADDR_W-1:0] y,
                                                  input logic [ADDR_W-1:0] k);
        logic [ADDR_W:0] s;
        s = {1'b0, x} - {1'b0, y};
        if (s[ADDR_W]) s = s + {1'b0, k};
        return s[ADDR_W-1:0];
    endfunction

    always_comb begin
        a_d = a_q;
        g_d = g_q;
        if (dir_q) begin
            a_d = mod_sub(a_q, g_q, blockSize);
            g_d = mod_sub(g_q, f2x2, blockSize);
        end else begin
            a_d = mod_add(a_q, g_q, blockSize);
            g_d = mod_add(g_q, f2x2, blockSize);
        end
    end

    assign handshake  = rd_valid_q & rd_ready;
    assign final_hs   = handshake & (rem_q == (WIN_W+1)'(1));
    assign load_ready = (state_q == IDLE) | final_hs;
    assign accept     = load & load_ready & (load_len != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            a_q        <= '0;
            g_q        <= '0;
            dir_q      <= 1'b0;
            rem_q      <= '0;
            rd_valid_q <= 1'b0;
            win_done_q <= 1'b0;
        end else begin
            win_done_q <= final_hs;
            // A load accepted on the final handshake takes priority so the next
            // window follows without a bubble.
            if (accept) begin
                state_q    <= RUN;
                a_q        <= load_A;
                g_q        <= load_G;
                dir_q      <= load_dir;
                rem_q      <= load_len;
                rd_valid_q <= 1'b1;
            end else if (final_hs) begin
                state_q    <= IDLE;
                rem_q      <= '0;
                rd_valid_q <= 1'b0;
            end else if (handshake) begin
                rem_q <= rem_q - 1'b1;
                a_q   <= a_d;
                g_q   <= g_d;
            end
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_addr  = a_q;
    assign rd_last  = rd_valid_q & (rem_q == (WIN_W+1)'(1));
    assign win_done = win_done_q;

endmodule

// File: tb/tb_le_read_addr_gen.sv
// Directed bench for le_read_addr_gen: table-driven windows plus hand-written
// sequences for reset, backpressure, back-to-back and ignored loads.
module tb_le_read_addr_gen;

    localparam int unsigned ADDR_W = 13;
    localparam int unsigned WIN_W  = 5;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [ADDR_W-1:0] blockSize = '0;
    logic [ADDR_W-1:0] f2x2 = '0;
    logic              load = 1'b0;
    logic              load_ready;
    logic              load_dir = 1'b0;
    logic [WIN_W:0]    load_len = '0;
    logic [ADDR_W-1:0] load_A = '0;
    logic [ADDR_W-1:0] load_G = '0;
    logic              rd_valid;
    logic              rd_ready = 1'b0;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_last;
    logic              win_done;

    int checks = 0;
    int errors = 0;

    le_read_addr_gen #(.ADDR_W(ADDR_W), .WIN_W(WIN_W)) dut (
        .clk(clk), .reset(reset), .blockSize(blockSize), .f2x2(f2x2),
        .load(load), .load_ready(load_ready), .load_dir(load_dir),
        .load_len(load_len), .load_A(load_A), .load_G(load_G),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_last(rd_last), .win_done(win_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              dir;
        logic [12:0]       k;
        logic [12:0]       f2;
        logic [12:0]       a;
        logic [12:0]       g;
        logic [5:0]        len;
        logic [0:7][12:0]  exp;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic dir, input logic [12:0] k, input logic [12:0] f2,
                         input logic [12:0] a, input logic [12:0] g, input logic [5:0] len);
        blockSize = k;
        f2x2      = f2;
        load_dir  = dir;
        load_A    = a;
        load_G    = g;
        load_len  = len;
        load      = 1'b1;
        tick();
        load      = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        rd_ready = 1'b1;
        start(v.dir, v.k, v.f2, v.a, v.g, v.len);
        for (int b = 0; b < int'(v.len); b++) begin
            chk("vec_valid", 32'(rd_valid), 32'd1);
            chk("vec_addr", 32'(rd_addr), 32'(v.exp[b]));
            chk("vec_last", 32'(rd_last), (b == int'(v.len) - 1) ? 32'd1 : 32'd0);
            chk("vec_win_done_mid", 32'(win_done), 32'd0);
            tick();
        end
        chk("vec_win_done", 32'(win_done), 32'd1);
        chk("vec_valid_end", 32'(rd_valid), 32'd0);
        tick();
        chk("vec_win_done_pulse", 32'(win_done), 32'd0);
    endtask

    initial begin
        logic [0:4][12:0] fwd_exp;
        int idx;

        fwd_exp = {13'd0, 13'd13, 13'd6, 13'd19, 13'd12};

        vecs[0] = '{dir: 1'b0, k: 13'd40, f2: 13'd20, a: 13'd0, g: 13'd13, len: 6'd5,
                    exp: {13'd0, 13'd13, 13'd6, 13'd19, 13'd12, 13'd0, 13'd0, 13'd0}};
        vecs[1] = '{dir: 1'b1, k: 13'd40, f2: 13'd20, a: 13'd12, g: 13'd33, len: 6'd4,
                    exp: {13'd12, 13'd19, 13'd6, 13'd13, 13'd0, 13'd0, 13'd0, 13'd0}};
        vecs[2] = '{dir: 1'b0, k: 13'd40, f2: 13'd20, a: 13'd39, g: 13'd39, len: 6'd3,
                    exp: {13'd39, 13'd38, 13'd17, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0}};
        vecs[3] = '{dir: 1'b1, k: 13'd16, f2: 13'd7, a: 13'd0, g: 13'd5, len: 6'd3,
                    exp: {13'd0, 13'd11, 13'd13, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0}};
        vecs[4] = '{dir: 1'b0, k: 13'd40, f2: 13'd20, a: 13'd5, g: 13'd3, len: 6'd1,
                    exp: {13'd5, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0}};

        // Reset state
        #12;
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_addr", 32'(rd_addr), 32'd0);
        chk("rst_last", 32'(rd_last), 32'd0);
        chk("rst_win_done", 32'(win_done), 32'd0);
        reset = 1'b1;
        tick();
        chk("rst_load_ready", 32'(load_ready), 32'd1);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Reset during beat 3 aborts the window silently
        rd_ready = 1'b1;
        start(1'b0, 13'd40, 13'd20, 13'd0, 13'd13, 6'd5);
        tick();
        tick();
        chk("abort_pre_addr", 32'(rd_addr), 32'd6);
        reset = 1'b0;
        #1;
        chk("abort_valid", 32'(rd_valid), 32'd0);
        chk("abort_last", 32'(rd_last), 32'd0);
        chk("abort_win_done", 32'(win_done), 32'd0);
        chk("abort_addr", 32'(rd_addr), 32'd0);
        tick();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("abort_no_win_done", 32'(win_done), 32'd0);
            chk("abort_idle_valid", 32'(rd_valid), 32'd0);
            chk("abort_load_ready", 32'(load_ready), 32'd1);
        end

        // Backpressure: ready pattern 1,0,0 repeating
        rd_ready = 1'b1;
        start(1'b0, 13'd40, 13'd20, 13'd0, 13'd13, 6'd5);
        idx = 0;
        for (int c = 0; c < 40 && idx < 5; c++) begin
            rd_ready = (c % 3 == 0);
            chk("bp_valid", 32'(rd_valid), 32'd1);
            chk("bp_addr", 32'(rd_addr), 32'(fwd_exp[idx]));
            chk("bp_last", 32'(rd_last), (idx == 4) ? 32'd1 : 32'd0);
            chk("bp_win_done_mid", 32'(win_done), 32'd0);
            tick();
            if (rd_ready) idx++;
        end
        chk("bp_beats", 32'(idx), 32'd5);
        chk("bp_win_done", 32'(win_done), 32'd1);
        chk("bp_valid_end", 32'(rd_valid), 32'd0);
        tick();

        // Back-to-back windows; a mid-window load is ignored
        rd_ready = 1'b1;
        start(1'b0, 13'd40, 13'd20, 13'd0, 13'd13, 6'd5);
        for (int b = 0; b < 5; b++) begin
            chk("b2b_addr", 32'(rd_addr), 32'(fwd_exp[b]));
            chk("b2b_valid", 32'(rd_valid), 32'd1);
            if (b < 4) begin
                load_dir = 1'b0;
                load_A   = 13'd7;
                load_G   = 13'd1;
                load_len = 6'd3;
                load     = (b < 3);
                #1;
                chk("b2b_busy_load_ready", 32'(load_ready), 32'd0);
            end else begin
                load_dir = 1'b1;
                load_A   = 13'd12;
                load_G   = 13'd33;
                load_len = 6'd2;
                load     = 1'b1;
                #1;
                chk("b2b_final_load_ready", 32'(load_ready), 32'd1);
                chk("b2b_final_last", 32'(rd_last), 32'd1);
            end
            tick();
        end
        load = 1'b0;
        chk("b2b_2nd_valid", 32'(rd_valid), 32'd1);
        chk("b2b_2nd_addr0", 32'(rd_addr), 32'd12);
        chk("b2b_win_done1", 32'(win_done), 32'd1);
        chk("b2b_2nd_last0", 32'(rd_last), 32'd0);
        tick();
        chk("b2b_2nd_addr1", 32'(rd_addr), 32'd19);
        chk("b2b_2nd_last1", 32'(rd_last), 32'd1);
        chk("b2b_win_done_gap", 32'(win_done), 32'd0);
        tick();
        chk("b2b_win_done2", 32'(win_done), 32'd1);
        chk("b2b_end_valid", 32'(rd_valid), 32'd0);
        tick();

        // Zero-length load is ignored
        load_len = 6'd0;
        load_A   = 13'd9;
        load     = 1'b1;
        tick();
        load = 1'b0;
        chk("len0_valid", 32'(rd_valid), 32'd0);
        chk("len0_load_ready", 32'(load_ready), 32'd1);
        tick();
        chk("len0_win_done", 32'(win_done), 32'd0);
        chk("len0_valid2", 32'(rd_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
